// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multi-cycle multiply/divide unit.
//   md_state_e : controller states (IDLE, MULT, DIV, FIN)
//   MD_OP_MULT / MD_OP_DIV : encodings of the 'op' request bit
//   MD_ITERS   : iterations per multiply or divide (one result bit per cycle)
//   MD_CNT_W   : width of the iteration counter
// ---------------------------------------------------------------------------
package md_pkg;

  localparam int MD_ITERS = 32;
  localparam int MD_CNT_W = 6;

  localparam logic MD_OP_MULT = 1'b0;
  localparam logic MD_OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } md_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// ---------------------------------------------------------------------------
// mult_div_unit_if
// Request/response bundle between the CPU control FSM and the mult/div unit.
//   start, op, a, b, hilo_write : driven by the controller (master)
//   busy, done, div0, hi, lo    : driven by the unit (slave)
// ---------------------------------------------------------------------------
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_write;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hilo_write,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b, hilo_write,
    output busy, done, div0, hi, lo
  );

endinterface

// File: rtl/md_sign_adjust.sv
// ---------------------------------------------------------------------------
// md_sign_adjust
// Combinational sign handling around the unsigned iteration datapath.
//   a, b           : raw operands (entry side)
//   sign_a, sign_b : operand sign bits, latched by the controller
//   mag_a, mag_b   : operand magnitudes fed to the iteration
//   op             : operation of the running request (MD_OP_MULT / MD_OP_DIV)
//   neg_a, neg_b   : latched operand signs
//   raw_hi, raw_lo : unsigned product (hi:lo) or remainder:quotient
//   res_hi, res_lo : signed-corrected result
// Build option: MD_SIGNED_EN selects two's complement semantics; without it
// operands are unsigned and every path is a straight pass-through.
// ---------------------------------------------------------------------------
module md_sign_adjust import md_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             sign_a,
  output logic             sign_b,
  output logic [WIDTH-1:0] mag_a,
  output logic [WIDTH-1:0] mag_b,
  input  logic             op,
  input  logic             neg_a,
  input  logic             neg_b,
  input  logic [WIDTH-1:0] raw_hi,
  input  logic [WIDTH-1:0] raw_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

`ifdef MD_SIGNED_EN
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sign_a = a[WIDTH-1];
    sign_b = b[WIDTH-1];
    // The most negative value maps onto itself, which is the correct
    // unsigned magnitude 2^(WIDTH-1).
    mag_a  = sign_a ? -a : a;
    mag_b  = sign_b ? -b : b;

    prod   = {raw_hi, raw_lo};
    res_hi = raw_hi;
    res_lo = raw_lo;
    if (op == MD_OP_MULT) begin
      if (neg_a ^ neg_b) begin
        prod = -prod;
      end
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
    end else begin
      // Quotient truncates toward zero; remainder follows the dividend.
      if (neg_a ^ neg_b) begin
        res_lo = -raw_lo;
      end
      if (neg_a) begin
        res_hi = -raw_hi;
      end
    end
  end
`else
  logic unused_sign;

  assign sign_a      = 1'b0;
  assign sign_b      = 1'b0;
  assign mag_a       = a;
  assign mag_b       = b;
  assign res_hi      = raw_hi;
  assign res_lo      = raw_lo;
  assign unused_sign = ^{op, neg_a, neg_b};
`endif

endmodule

// File: rtl/mult_div_unit.sv
// ---------------------------------------------------------------------------
// mult_div_unit
// Multi-cycle integer multiply/divide with architectural HI/LO registers.
// Shift-add multiply and restoring divide, one result bit per cycle over
// MD_ITERS cycles, sharing one double-width accumulator.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mult_div_unit_if.slave
//             start/op/a/b  request (accepted only in IDLE)
//             hilo_write    commit result registers into hi/lo
//             busy          iteration in progress
//             done          one-cycle pulse, result registers valid
//             div0          last accepted divide had b == 0 (sticky)
//             hi/lo         architectural HI/LO
// Build option: define MD_SIGNED_EN for signed (mult/div) semantics; the
// default build is unsigned (multu/divu). Cycle timing is the same in both.
// ---------------------------------------------------------------------------
module mult_div_unit import md_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);

  localparam logic [MD_CNT_W-1:0] LAST_CNT = MD_CNT_W'(MD_ITERS - 1);

  md_state_e           state;
  logic [MD_CNT_W-1:0] cnt;
  logic                op_q;
  logic                neg_a_q;
  logic                neg_b_q;
  logic [WIDTH-1:0]    opnd_q;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]  acc_q;      // mult: {partial, multiplier}; div: {rem, quot}
  logic [WIDTH-1:0]    res_hi;
  logic [WIDTH-1:0]    res_lo;
  logic [WIDTH-1:0]    hi_q;
  logic [WIDTH-1:0]    lo_q;
  logic                busy_q;
  logic                done_q;
  logic                div0_q;

  logic                sign_a;
  logic                sign_b;
  logic [WIDTH-1:0]    mag_a;
  logic [WIDTH-1:0]    mag_b;
  logic [WIDTH-1:0]    fix_hi;
  logic [WIDTH-1:0]    fix_lo;

  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      div_shift;
  logic [WIDTH+1:0]    div_diff;
  logic [2*WIDTH-1:0]  acc_next;

  // The fix-up sees the accumulator value of the final iteration so that
  // done and the corrected result register on the same edge.
  md_sign_adjust #(.WIDTH(WIDTH)) u_sign (
    .a      (bus.a),
    .b      (bus.b),
    .sign_a (sign_a),
    .sign_b (sign_b),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .op     (op_q),
    .neg_a  (neg_a_q),
    .neg_b  (neg_b_q),
    .raw_hi (acc_next[2*WIDTH-1:WIDTH]),
    .raw_lo (acc_next[WIDTH-1:0]),
    .res_hi (fix_hi),
    .res_lo (fix_lo)
  );

  // ---- iteration step ----
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    if (op_q == MD_OP_DIV) begin
      // Borrow out of the trial subtract means the divisor did not fit.
      if (!div_diff[WIDTH+1]) begin
        acc_next = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // ---- controller, result and HI/LO registers ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
      res_hi <= '0;
      res_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q    <= bus.op;
            neg_a_q <= sign_a;
            neg_b_q <= sign_b;
            div0_q  <= 1'b0;
            cnt     <= '0;
            if (bus.op == MD_OP_MULT) begin
              opnd_q <= mag_a;
              acc_q  <= {{WIDTH{1'b0}}, mag_b};
              busy_q <= 1'b1;
              state  <= MULT;
            end else if (bus.b != '0) begin
              opnd_q <= mag_b;
              acc_q  <= {{WIDTH{1'b0}}, mag_a};
              busy_q <= 1'b1;
              state  <= DIV;
            end else begin
              // Divide by zero: report immediately, keep old results.
              div0_q <= 1'b1;
              done_q <= 1'b1;
              state  <= FIN;
            end
          end
        end
        MULT, DIV: begin
          acc_q <= acc_next;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            res_hi <= fix_hi;
            res_lo <= fix_lo;
            state  <= FIN;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (bus.hilo_write && !busy_q && !div0_q) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// ---------------------------------------------------------------------------
// tb_mult_div_unit
// Self-checking bench for mult_div_unit. Expected results come from native
// 64-bit arithmetic (signed when MD_SIGNED_EN is defined, unsigned otherwise)
// and are queued at issue time, then popped when the unit reports done.
// ---------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int W = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int           lat;
    int           busy_n;
    bit           div0;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [W-1:0] mdl_hi   = '0;
  logic [W-1:0] mdl_lo   = '0;

  function automatic logic [2*W-1:0] model(input logic op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
`ifdef MD_SIGNED_EN
    longint sa, sv, p, q, r;
    sa = $signed(a);
    sv = $signed(b);
    if (op == 1'b0) begin
      p = sa * sv;
      return p;
    end
    q = sa / sv;
    r = sa % sv;
    return {r[W-1:0], q[W-1:0]};
`else
    longint unsigned ua, uv, p, q, r;
    ua = a;
    uv = b;
    if (op == 1'b0) begin
      p = ua * uv;
      return p;
    end
    q = ua / uv;
    r = ua % uv;
    return {r[W-1:0], q[W-1:0]};
`endif
  endfunction

  // Issue one operation, optionally try extra starts at sample indices inj1/inj2
  // (sample k is the falling edge k cycles after the accepting edge), and
  // optionally pulse hilo_write in the done cycle.
  task automatic do_op(input string name, input logic op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit commit, input int inj1,
                       input int inj2);
    exp_t           e;
    exp_t           got;
    logic [2*W-1:0] r;
    int             busy_n;
    int             done_at;
    logic           d0;
    bit             is_div0;

    is_div0  = (op == 1'b1) && (b == '0);
    e.div0   = is_div0;
    e.lat    = is_div0 ? 1 : 33;
    e.busy_n = is_div0 ? 0 : 32;
    e.hi     = mdl_hi;
    e.lo     = mdl_lo;
    if (!is_div0 && commit) begin
      r    = model(op, a, b);
      e.hi = r[2*W-1:W];
      e.lo = r[W-1:0];
    end
    sb.push_back(e);

    @(negedge clock);
    bus.start      = 1'b1;
    bus.op         = op;
    bus.a          = a;
    bus.b          = b;
    bus.hilo_write = 1'b0;
    busy_n  = 0;
    done_at = 0;
    d0      = 1'bx;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      bus.start = (k == inj1) || (k == inj2);
      if (bus.start) begin
        bus.op = 1'b0;
        bus.a  = 32'h5A5A_0003;
        bus.b  = 32'h0000_0101;
      end
      if (bus.busy === 1'b1) busy_n++;
      if (bus.done === 1'b1) begin
        done_at = k;
        d0      = bus.div0;
        if (commit) bus.hilo_write = 1'b1;
        break;
      end
    end
    got = sb.pop_front();

    n_checks++;
    if (done_at !== got.lat)
      $display("FAIL %s latency: done at cycle %0d, expected %0d", name, done_at, got.lat);
    else n_pass++;

    n_checks++;
    if (busy_n !== got.busy_n)
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_n, got.busy_n);
    else n_pass++;

    n_checks++;
    if (d0 !== got.div0)
      $display("FAIL %s div0: got %b expected %b", name, d0, got.div0);
    else n_pass++;

    @(negedge clock);
    bus.start      = 1'b0;
    bus.hilo_write = 1'b0;

    n_checks++;
    if ({bus.done, bus.busy} !== 2'b00)
      $display("FAIL %s idle_after: done/busy %b%b expected 00", name, bus.done, bus.busy);
    else n_pass++;

    n_checks++;
    if (bus.hi !== got.hi || bus.lo !== got.lo)
      $display("FAIL %s hilo: hi=%h lo=%h expected hi=%h lo=%h", name, bus.hi, bus.lo,
               got.hi, got.lo);
    else n_pass++;

    mdl_hi = got.hi;
    mdl_lo = got.lo;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({bus.busy, bus.done, bus.div0} !== 3'b000 || bus.hi !== '0 || bus.lo !== '0)
      $display("FAIL reset_state: busy=%b done=%b div0=%b hi=%h lo=%h expected all 0",
               bus.busy, bus.done, bus.div0, bus.hi, bus.lo);
    else n_pass++;
    reset = 1'b0;
    mdl_hi = '0;
    mdl_lo = '0;
  endtask

  task automatic test_mul();
    do_op("mul_7_m3", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 0, 0);
    do_op("mul_ffff_2", 1'b0, 32'hFFFF_FFFF, 32'd2, 1'b1, 0, 0);
    do_op("mul_min_min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b1, 0, 0);
    do_op("mul_zero", 1'b0, 32'h1234_5678, 32'd0, 1'b1, 0, 0);
  endtask

  task automatic test_div();
    do_op("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1, 0, 0);
    do_op("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 0);
    do_op("div_ffff_2", 1'b1, 32'hFFFF_FFFF, 32'd2, 1'b1, 0, 0);
    do_op("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 0, 0);
  endtask

  task automatic test_div0();
    // 0x451 / 0x20 leaves hi = 0x11, lo = 0x22 in either build.
    do_op("div0_setup", 1'b1, 32'h0000_0451, 32'h0000_0020, 1'b1, 0, 0);
    do_op("div0", 1'b1, 32'd5, 32'd0, 1'b1, 0, 0);
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.div0 !== 1'b1 || bus.hi !== 32'h11 || bus.lo !== 32'h22)
      $display("FAIL div0_sticky: div0=%b hi=%h lo=%h expected 1/00000011/00000022",
               bus.div0, bus.hi, bus.lo);
    else n_pass++;
    do_op("div0_clear", 1'b0, 32'd9, 32'd11, 1'b1, 0, 0);
  endtask

  task automatic test_busy_reject();
    do_op("reject_mul", 1'b0, 32'h0001_0003, 32'h0000_0077, 1'b1, 5, 33);
    do_op("reject_div", 1'b1, 32'hABCD_0123, 32'h0000_0345, 1'b1, 5, 33);
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    @(negedge clock);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd123;
    bus.b     = 32'd456;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clock);
      bus.start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if ({bus.busy, bus.done, bus.div0} !== 3'b000 || bus.hi !== '0 || bus.lo !== '0)
      $display("FAIL reset_mid_state: busy=%b done=%b div0=%b hi=%h lo=%h expected all 0",
               bus.busy, bus.done, bus.div0, bus.hi, bus.lo);
    else n_pass++;
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen_done = 1'b1;
    end
    n_checks++;
    if (seen_done)
      $display("FAIL reset_mid_quiet: got activity after abort, expected none");
    else n_pass++;
    mdl_hi = '0;
    mdl_lo = '0;
    do_op("reset_mid_fresh", 1'b0, 32'd123, 32'd456, 1'b1, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i == 4) rb = rb >> 20;
      if (rb == '0) rb = 32'd1;
      do_op($sformatf("rand%0d", i), 1'(i % 2), ra, rb, (i != 3), 0, 0);
    end
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.op         = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.hilo_write = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_div0();
    test_busy_reject();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (sb.size() != 0)
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
